alu_issue_stage: RTL and testbench

Registered issue and result stage wrapped around the combinational ALU datapath, which includes the 32-bit bitwise units.
- Accepts `{op, A, B}` requests on a valid/ready handshake and buffers them in a small FIFO.
- Presents the head entry to the ALU as stable registered operands for a programmable settle time.
- Captures the ALU result, with a zero flag, into an output register held until the consumer accepts it.

---
 rtl/alu_issue_stage.sv | 134 +++++++++++++
 tb/tb_alu_issue_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/result stage around a combinational ALU: buffers {op, a, b} requests in a small FIFO,
// holds the head operands stable for ALU_LAT cycles, then registers the result with a zero flag.
module alu_issue_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPW     = 3,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StWaitOut} state_e;

  logic [OPW-1:0]   mem_op [DEPTH];
  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             push, capture, slot_free, settled;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign settled   = (cnt_q == LW'(ALU_LAT - 1));

  assign alu_op = mem_op[rd_ptr_q];
  assign alu_a  = mem_a[rd_ptr_q];
  assign alu_b  = mem_b[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (push) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (settled) begin
          if (slot_free) capture = 1'b1;
          else           state_d = StWaitOut;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitOut: begin
        if (slot_free) capture = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Entries left after the pop, counting a same-cycle push, keep the pipe busy.
    if (capture) begin
      cnt_d   = '0;
      state_d = ((count_q > CW'(1)) || push) ? StSettle : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i] <= '0;
        mem_a[i]  <= '0;
        mem_b[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_op[wr_ptr_q] <= in_op;
        mem_a[wr_ptr_q]  <= in_a;
        mem_b[wr_ptr_q]  <= in_b;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (capture) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, capture})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_op    <= '0;
      out_zero  <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_r     <= alu_r;
      out_op    <= alu_op;
      out_zero  <= (alu_r == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with an XOR ALU model; one instance at ALU_LAT=1,
// a second at ALU_LAT=3 for the settle-time scenario.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ALU_LAT = 1 instance
  logic        v1, rdy1, ordy1, ov1, oz1;
  logic [2:0]  op1, aop1, oop1;
  logic [31:0] a1, b1, aa1, ab1, r1, or1;
  assign r1 = aa1 ^ ab1;

  // ALU_LAT = 3 instance
  logic        v3, rdy3, ordy3, ov3, oz3;
  logic [2:0]  op3, aop3, oop3;
  logic [31:0] a3, b3, aa3, ab3, r3, or3;
  assign r3 = aa3 ^ ab3;

  alu_issue_stage #(.WIDTH(32), .OPW(3), .DEPTH(2), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_op(op1), .in_a(a1),
    .in_b(b1), .alu_op(aop1), .alu_a(aa1), .alu_b(ab1), .alu_r(r1), .out_valid(ov1),
    .out_ready(ordy1), .out_r(or1), .out_op(oop1), .out_zero(oz1)
  );

  alu_issue_stage #(.WIDTH(32), .OPW(3), .DEPTH(2), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_op(op3), .in_a(a3),
    .in_b(b3), .alu_op(aop3), .alu_a(aa3), .alu_b(ab3), .alu_r(r3), .out_valid(ov3),
    .out_ready(ordy3), .out_r(or3), .out_op(oop3), .out_zero(oz3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [34:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: handshakes seen here are the ones the next rising edge commits.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1 && ordy1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'(or1), 64'hdead);
        end else begin
          logic [34:0] e;
          e = sb.pop_front();
          check("sb_out_op", 64'(oop1), 64'(e[34:32]));
          check("sb_out_r", 64'(or1), 64'(e[31:0]));
          check("sb_out_zero", 64'(oz1), 64'(e[31:0] == 32'd0));
          n_out++;
        end
      end
      if (v1 && rdy1) sb.push_back({op1, a1 ^ b1});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ones, drops, acc, stale, base, wrap_acc;
    logic [31:0] first_r;
    v1 = 0; op1 = 0; a1 = 0; b1 = 0; ordy1 = 0;
    v3 = 0; op3 = 0; a3 = 0; b3 = 0; ordy3 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 64'(rdy1), 64'd1);
    check("rst_out_valid", 64'(ov1), 64'd0);
    check("rst_out_r", 64'(or1), 64'd0);
    check("rst_out_op", 64'(oop1), 64'd0);
    check("rst_out_zero", 64'(oz1), 64'd0);
    check("rst_alu_a", 64'(aa1), 64'd0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    check("post_rst_in_ready", 64'(rdy1), 64'd1);

    // Single request latency
    @(posedge clk); #1;
    ordy1 = 1; v1 = 1; op1 = 3'd3; a1 = 32'hF0F0F0F0; b1 = 32'h0FF00FF0;
    @(posedge clk); #1;
    v1 = 0;
    check("lat_not_yet", 64'(ov1), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(ov1), 64'd1);
    check("lat_out_r", 64'(or1), 64'hFF00FF00);
    check("lat_out_op", 64'(oop1), 64'd3);
    check("lat_out_zero", 64'(oz1), 64'd0);
    @(posedge clk); #1;
    check("lat_consumed", 64'(ov1), 64'd0);

    // Back-to-back throughput
    ones = 0; drops = 0; base = n_out;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i >= 2 && ov1) ones++;
      if (!rdy1) drops++;
      v1 = 1; op1 = 3'(i); a1 = $urandom; b1 = $urandom;
    end
    @(posedge clk); #1; v1 = 0; if (ov1) ones++;
    @(posedge clk); #1; if (ov1) ones++;
    @(posedge clk); #1;
    check("b2b_valid_cycles", 64'(ones), 64'd8);
    check("b2b_ready_drops", 64'(drops), 64'd0);
    check("b2b_idle_after", 64'(ov1), 64'd0);
    check("b2b_outputs", 64'(n_out - base), 64'd8);

    // Backpressure and full
    ordy1 = 0; acc = 0;
    v1 = 1; op1 = 3'd1; a1 = $urandom; b1 = $urandom;
    first_r = a1 ^ b1;
    for (int k = 0; k < 6; k++) begin
      if (v1 && rdy1) acc++;
      @(posedge clk); #1;
      op1 = 3'(k + 2); a1 = $urandom; b1 = $urandom;
    end
    v1 = 0;
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready_low", 64'(rdy1), 64'd0);
    check("bp_out_valid", 64'(ov1), 64'd1);
    check("bp_out_r_held", 64'(or1), 64'(first_r));
    ordy1 = 1; ones = 0;
    @(posedge clk); #1; if (ov1) ones++;
    @(posedge clk); #1; if (ov1) ones++;
    check("bp_drain_consecutive", 64'(ones), 64'd2);
    @(posedge clk); #1;
    check("bp_drained", 64'(ov1), 64'd0);

    // Settle time on the ALU_LAT=3 instance
    ordy3 = 1; v3 = 1; op3 = 3'd5; a3 = 32'h12345678; b3 = 32'h12345678;
    @(posedge clk); #1;
    v3 = 0; a3 = 0; b3 = 0;
    for (int j = 0; j < 3; j++) begin
      check("settle_alu_a", 64'(aa3), 64'h12345678);
      check("settle_alu_b", 64'(ab3), 64'h12345678);
      check("settle_no_valid", 64'(ov3), 64'd0);
      @(posedge clk); #1;
    end
    check("settle_valid", 64'(ov3), 64'd1);
    check("settle_out_r", 64'(or3), 64'd0);
    check("settle_out_zero", 64'(oz3), 64'd1);
    check("settle_out_op", 64'(oop3), 64'd5);

    // Reset mid-operation: two buffered plus one pending output
    ordy1 = 0; v1 = 1;
    for (int k = 0; k < 4; k++) begin
      op1 = 3'(k); a1 = $urandom; b1 = $urandom;
      @(posedge clk); #1;
    end
    v1 = 0;
    check("mid_full", 64'(rdy1), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ov1), 64'd0);
    check("mid_rst_in_ready", 64'(rdy1), 64'd1);
    sb.delete();
    #3 rst_n = 1'b1;
    ordy1 = 1; stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ov1) stale++;
    end
    check("mid_no_stale", 64'(stale), 64'd0);

    // Pointer wrap with toggling out_ready
    base = n_out; wrap_acc = 0;
    v1 = 1; op1 = 3'd7; a1 = $urandom; b1 = $urandom;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (v1 && rdy1) wrap_acc++;
      @(posedge clk); #1;
      ordy1 = (cyc % 3 != 0);
      if (wrap_acc >= 5) v1 = 0;
      else begin
        op1 = 3'(cyc); a1 = $urandom; b1 = (cyc % 4 == 0) ? a1 : $urandom;
      end
    end
    ordy1 = 1;
    for (int k = 0; k < 20 && (sb.size() != 0 || ov1); k++) begin
      @(posedge clk); #1;
    end
    check("wrap_accepted", 64'(wrap_acc), 64'd5);
    check("wrap_outputs", 64'(n_out - base), 64'd5);
    check("wrap_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
